// File: rtl/mmio_bus_bridge_pkg.sv
// mmio_bus_bridge_pkg
//   Shared definitions for the MMIO bus bridge:
//   - op_t        CPU memory operation codes (OP_NONE .. OP_SB)
//   - EXC_*       exception codes reported on cpu_exc_out
//   - state_t     bridge FSM states
//   - helpers     op classification, lane enables, lane-shifted store data
//                 and load extension
package mmio_bus_bridge_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } op_t;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_BUSY,
    S_DONE
  } state_t;

  // Codes outside the table are never accepted, so they behave like OP_NONE.
  function automatic logic op_valid(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  function automatic logic op_is_store(input op_t op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic op_is_word(input op_t op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic op_is_half(input op_t op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic [3:0] lane_byteen(input op_t op, input logic [1:0] lane);
    case (op)
      OP_SH:   return 4'b0011 << lane;
      OP_SB:   return 4'b0001 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data arrives in the low bits and is moved onto the addressed lanes;
  // lanes that are not enabled carry zero.
  function automatic logic [31:0] lane_wdata(input op_t op, input logic [1:0] lane,
                                             input logic [31:0] wdata);
    case (op)
      OP_SW:   return wdata;
      OP_SH:   return {16'h0, wdata[15:0]} << {lane, 3'b000};
      OP_SB:   return {24'h0, wdata[7:0]} << {lane, 3'b000};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input op_t op, input logic [1:0] lane,
                                              input logic [31:0] raw);
    case (op)
      OP_LW:   return raw;
      OP_LH:   return {{16{raw[{lane[1], 4'b1111}]}}, raw[{lane[1], 4'b0000} +: 16]};
      OP_LHU:  return {16'h0, raw[{lane[1], 4'b0000} +: 16]};
      OP_LB:   return {{24{raw[{lane, 3'b111}]}}, raw[{lane, 3'b000} +: 8]};
      OP_LBU:  return {24'h0, raw[{lane, 3'b000} +: 8]};
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/mmio_bus_bridge_if.sv
// mmio_bus_bridge_if
//   Device-side bus between the bridge and NUM_DEV memory-mapped slaves.
//   dev_req     one-hot slave select, held until the selected slave acks
//   dev_we      write qualifier
//   dev_addr    latched byte address
//   dev_byteen  lane enables (1111 on reads)
//   dev_wdata   lane-shifted store data
//   dev_rdata   flattened read data, slot i at [32*i+:32]
//   dev_ack     per-slot completion
//   Modports: master (bridge side), slave (device side).
interface mmio_bus_bridge_if #(
  parameter int NUM_DEV = 8
);
  logic [NUM_DEV-1:0]    dev_req;
  logic                  dev_we;
  logic [31:0]           dev_addr;
  logic [3:0]            dev_byteen;
  logic [31:0]           dev_wdata;
  logic [32*NUM_DEV-1:0] dev_rdata;
  logic [NUM_DEV-1:0]    dev_ack;

  modport master (
    output dev_req, dev_we, dev_addr, dev_byteen, dev_wdata,
    input  dev_rdata, dev_ack
  );

  modport slave (
    input  dev_req, dev_we, dev_addr, dev_byteen, dev_wdata,
    output dev_rdata, dev_ack
  );
endinterface

// File: rtl/mmio_bus_bridge_addr_decode.sv
// mmio_bus_bridge_addr_decode
//   Combinational base/limit table decode.
//   addr        in   byte address to decode
//   hit         out  some slot covers addr
//   sel         out  one-hot winning slot (lowest index on overlap)
//   subword_ok  out  winning slot accepts half/byte accesses
//   ro          out  winning slot is read-only
module mmio_bus_bridge_addr_decode #(
  parameter int                    NUM_DEV     = 8,
  parameter logic [32*NUM_DEV-1:0] DEV_BASE    = '0,
  parameter logic [32*NUM_DEV-1:0] DEV_LIMIT   = '0,
  parameter logic [NUM_DEV-1:0]    DEV_SUBWORD = '1,
  parameter logic [NUM_DEV-1:0]    DEV_RO      = '0
) (
  input  logic [31:0]        addr,
  output logic               hit,
  output logic [NUM_DEV-1:0] sel,
  output logic               subword_ok,
  output logic               ro
);

  // Scan from the highest slot down so that the lowest matching slot is the
  // last one written and therefore wins on overlapping ranges.
  always_comb begin
    hit        = 1'b0;
    sel        = '0;
    subword_ok = 1'b0;
    ro         = 1'b0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if ((addr >= DEV_BASE[32*i +: 32]) && (addr <= DEV_LIMIT[32*i +: 32])) begin
        hit        = 1'b1;
        sel        = '0;
        sel[i]     = 1'b1;
        subword_ok = DEV_SUBWORD[i];
        ro         = DEV_RO[i];
      end
    end
  end

endmodule

// File: rtl/mmio_bus_bridge.sv
// mmio_bus_bridge
//   CPU MEM-stage to memory-mapped slave bridge. Accepts one access in IDLE,
//   checks it (CHECK), runs a req/ack handshake with the selected slave (BUSY)
//   and returns a one-cycle completion with extended load data (DONE).
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     cpu_req/op/addr/wdata/exc_in/flush   CPU request side
//     cpu_stall/ack/rdata/exc_out          CPU response side
//     dev               mmio_bus_bridge_if.master device bus
//   Optional feature: define BRIDGE_TIMEOUT_EN to abort a slave access that
//   has not acked after TIMEOUT_CYC BUSY cycles (reported as AdEL/AdES).
module mmio_bus_bridge
  import mmio_bus_bridge_pkg::*;
#(
  parameter int                    NUM_DEV     = 8,
  parameter logic [32*NUM_DEV-1:0] DEV_BASE    = '0,
  parameter logic [32*NUM_DEV-1:0] DEV_LIMIT   = '0,
  parameter logic [NUM_DEV-1:0]    DEV_SUBWORD = '1,
  parameter logic [NUM_DEV-1:0]    DEV_RO      = '0
`ifdef BRIDGE_TIMEOUT_EN
  ,
  parameter int                    TIMEOUT_CYC = 255
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic [3:0]          cpu_op,
  input  logic [31:0]         cpu_addr,
  input  logic [31:0]         cpu_wdata,
  input  logic [4:0]          cpu_exc_in,
  input  logic                cpu_flush,
  output logic                cpu_stall,
  output logic                cpu_ack,
  output logic [31:0]         cpu_rdata,
  output logic [4:0]          cpu_exc_out,
  mmio_bus_bridge_if.master   dev
);

  state_t             state, state_next;
  op_t                op_q;
  logic [31:0]        addr_q, wdata_q, rdata_q;
  logic [4:0]         exc_q;
  logic [NUM_DEV-1:0] sel_q;

  logic               accept;
  logic               dec_hit, dec_subword_ok, dec_ro;
  logic [NUM_DEV-1:0] dec_sel;
  logic [4:0]         fault_code, check_exc;
  logic               ack_sel;
  logic [31:0]        rdata_sel;
  logic               timeout_hit;

  assign accept     = (state == S_IDLE) && cpu_req && op_valid(cpu_op) && !cpu_flush;
  assign fault_code = op_is_store(op_q) ? EXC_ADES : EXC_ADEL;

  mmio_bus_bridge_addr_decode #(
    .NUM_DEV     (NUM_DEV),
    .DEV_BASE    (DEV_BASE),
    .DEV_LIMIT   (DEV_LIMIT),
    .DEV_SUBWORD (DEV_SUBWORD),
    .DEV_RO      (DEV_RO)
  ) u_decode (
    .addr       (addr_q),
    .hit        (dec_hit),
    .sel        (dec_sel),
    .subword_ok (dec_subword_ok),
    .ro         (dec_ro)
  );

  // Exception priority: upstream code first, then alignment, decode miss,
  // sub-word to a word-only slot, and finally a store to a read-only slot.
  always_comb begin
    check_exc = EXC_NONE;
    if (exc_q != EXC_NONE)
      check_exc = exc_q;
    else if ((op_is_word(op_q) && (addr_q[1:0] != 2'b00)) ||
             (op_is_half(op_q) && addr_q[0]))
      check_exc = fault_code;
    else if (!dec_hit)
      check_exc = fault_code;
    else if (!op_is_word(op_q) && !dec_subword_ok)
      check_exc = fault_code;
    else if (op_is_store(op_q) && dec_ro)
      check_exc = fault_code;
  end

  // Only the selected slot's ack and read data are looked at.
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (sel_q[i])
        rdata_sel = rdata_sel | dev.dev_rdata[32*i +: 32];
    end
  end
  assign ack_sel = |(dev.dev_ack & sel_q);

`ifdef BRIDGE_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Counts BUSY cycles; cleared as the access enters BUSY.
  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= '0;
    else if (state == S_CHECK)
      wait_cnt <= '0;
    else if (state == S_BUSY)
      wait_cnt <= wait_cnt + 8'd1;
  end

  assign timeout_hit = (wait_cnt == 8'(TIMEOUT_CYC - 1)) && !ack_sel;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_CHECK;
      S_CHECK: state_next = (check_exc != EXC_NONE) ? S_DONE : S_BUSY;
      S_BUSY:  if (ack_sel || timeout_hit) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request latch, check result, slave select and captured read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      exc_q   <= EXC_NONE;
      sel_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q    <= op_t'(cpu_op);
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            exc_q   <= cpu_exc_in;
            rdata_q <= '0;
          end
        end
        S_CHECK: begin
          exc_q <= check_exc;
          sel_q <= (check_exc == EXC_NONE) ? dec_sel : '0;
        end
        S_BUSY: begin
          if (ack_sel)
            rdata_q <= rdata_sel;
          else if (timeout_hit)
            exc_q <= fault_code;
        end
        default: ;
      endcase
    end
  end

  // Stall covers the accepting cycle combinationally and releases in DONE.
  always_comb begin
    cpu_stall      = accept || (state == S_CHECK) || (state == S_BUSY);
    cpu_ack        = (state == S_DONE);
    cpu_exc_out    = (state == S_DONE) ? exc_q : EXC_NONE;
    cpu_rdata      = '0;
    if ((state == S_DONE) && (exc_q == EXC_NONE) && !op_is_store(op_q))
      cpu_rdata = load_extend(op_q, addr_q[1:0], rdata_q);
    dev.dev_req    = '0;
    dev.dev_we     = 1'b0;
    dev.dev_addr   = '0;
    dev.dev_byteen = 4'b0000;
    dev.dev_wdata  = '0;
    if (state == S_BUSY) begin
      dev.dev_req    = sel_q;
      dev.dev_we     = op_is_store(op_q);
      dev.dev_addr   = addr_q;
      dev.dev_byteen = lane_byteen(op_q, addr_q[1:0]);
      dev.dev_wdata  = lane_wdata(op_q, addr_q[1:0], wdata_q);
    end
  end

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// tb_mmio_bus_bridge
//   Self-checking bench for mmio_bus_bridge (default build, no timeout).
//   Map: slot0 0x0000-0x2FFF, slot1 0x7000-0x7FFF, slot2 0x7800-0x8FFF
//   (word-only, overlaps slot1), slot3 0xA000-0xAFFF (read-only).
module tb_mmio_bus_bridge;
  import mmio_bus_bridge_pkg::*;

  localparam int NDEV = 4;
  localparam logic [32*NDEV-1:0] BASE  = {32'h0000_A000, 32'h0000_7800, 32'h0000_7000, 32'h0000_0000};
  localparam logic [32*NDEV-1:0] LIMIT = {32'h0000_AFFF, 32'h0000_8FFF, 32'h0000_7FFF, 32'h0000_2FFF};
  localparam logic [NDEV-1:0] SUBWORD = 4'b1011;
  localparam logic [NDEV-1:0] RO      = 4'b1000;

  logic [31:0] m_base  [NDEV] = '{32'h0000, 32'h7000, 32'h7800, 32'hA000};
  logic [31:0] m_limit [NDEV] = '{32'h2FFF, 32'h7FFF, 32'h8FFF, 32'hAFFF};
  bit          m_sub   [NDEV] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit          m_ro    [NDEV] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic [3:0]  cpu_op = 4'd0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [4:0]  cpu_exc_in = '0;
  logic        cpu_flush = 1'b0;
  logic        cpu_stall, cpu_ack;
  logic [31:0] cpu_rdata;
  logic [4:0]  cpu_exc_out;

  int checks = 0;
  int failures = 0;

  mmio_bus_bridge_if #(.NUM_DEV(NDEV)) bus ();

  mmio_bus_bridge #(
    .NUM_DEV(NDEV), .DEV_BASE(BASE), .DEV_LIMIT(LIMIT),
    .DEV_SUBWORD(SUBWORD), .DEV_RO(RO)
  ) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_op(cpu_op),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_exc_in(cpu_exc_in),
    .cpu_flush(cpu_flush), .cpu_stall(cpu_stall), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .cpu_exc_out(cpu_exc_out), .dev(bus.master)
  );

  always #5 clk = ~clk;

  // Slave model: acks after wait_n extra cycles of dev_req; unselected slots
  // may raise stray acks that the bridge must ignore.
  int              wait_n = 0;
  int              req_cycles = 0;
  logic [NDEV-1:0] ack_noise = '0;
  logic [31:0]     slave_data [NDEV];

  always @(posedge clk) req_cycles <= (|bus.dev_req) ? req_cycles + 1 : 0;
  assign bus.dev_ack = ((req_cycles >= wait_n) ? bus.dev_req : '0) | (ack_noise & ~bus.dev_req);

  task automatic load_slaves();
    for (int i = 0; i < NDEV; i++) bus.dev_rdata[32*i +: 32] = slave_data[i];
  endtask

  // Observations of one access
  int              obs_ack_cycle, obs_ack_count, obs_req_cycles;
  logic [31:0]     obs_rdata, obs_wdata, obs_addr;
  logic [4:0]      obs_exc;
  logic [NDEV-1:0] obs_sel;
  logic            obs_we, obs_stall_bad, obs_accept_stall;
  logic [3:0]      obs_byteen;

  // Reference expectations
  int              exp_slot;
  logic [4:0]      exp_exc;
  logic [31:0]     exp_rdata, exp_wdata;
  logic [3:0]      exp_byteen;
  logic            exp_we;
  logic [NDEV-1:0] exp_sel;

  // Drives one request and records what the bridge does until one cycle
  // after its completion (or a 60-cycle bound expires).
  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] exc,
                                input int waits, input logic flush_mid);
    obs_ack_cycle = -1; obs_ack_count = 0; obs_req_cycles = 0;
    obs_rdata = '0; obs_wdata = '0; obs_addr = '0; obs_exc = '0; obs_sel = '0;
    obs_we = 1'b0; obs_byteen = '0; obs_stall_bad = 1'b0;
    @(negedge clk);
    wait_n = waits;
    cpu_req = 1'b1; cpu_op = op; cpu_addr = addr; cpu_wdata = wdata;
    cpu_exc_in = exc; cpu_flush = 1'b0;
    #1 obs_accept_stall = cpu_stall;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        cpu_req = 1'b0; cpu_op = 4'd0; cpu_exc_in = '0; cpu_flush = flush_mid;
      end
      #1;
      if (|bus.dev_req) begin
        obs_req_cycles++;
        obs_sel = bus.dev_req; obs_we = bus.dev_we; obs_byteen = bus.dev_byteen;
        obs_wdata = bus.dev_wdata; obs_addr = bus.dev_addr;
      end
      if (cpu_ack) begin
        obs_ack_count++;
        if (obs_ack_count == 1) begin
          obs_ack_cycle = cyc; obs_rdata = cpu_rdata; obs_exc = cpu_exc_out;
        end
        if (cpu_stall) obs_stall_bad = 1'b1;
      end else if (obs_ack_count == 0 && !cpu_stall) begin
        obs_stall_bad = 1'b1;
      end
      if (obs_ack_count > 0 && cyc >= obs_ack_cycle + 2) break;
    end
    cpu_flush = 1'b0;
  endtask

  // Reference model built from the address map and access rules.
  task automatic ref_model(input int op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] exc);
    bit     store, sgn;
    int     size, off;
    longint v;
    store = (op == 6) || (op == 7) || (op == 8);
    size  = (op == 1 || op == 6) ? 4 : ((op == 2 || op == 3 || op == 7) ? 2 : 1);
    sgn   = (op == 2) || (op == 4);
    off   = int'(addr % 4);
    exp_slot = -1;
    for (int i = 0; i < NDEV; i++)
      if (exp_slot < 0 && addr >= m_base[i] && addr <= m_limit[i]) exp_slot = i;
    exp_exc = 5'd0; exp_rdata = '0; exp_wdata = '0; exp_byteen = '0; exp_we = 1'b0; exp_sel = '0;
    if (exc != 0)                              exp_exc = exc;
    else if (addr % size != 0)                 exp_exc = store ? 5'd5 : 5'd4;
    else if (exp_slot < 0)                     exp_exc = store ? 5'd5 : 5'd4;
    else if (size < 4 && !m_sub[exp_slot])     exp_exc = 5'd5 - (store ? 5'd0 : 5'd1);
    else if (store && m_ro[exp_slot])          exp_exc = 5'd5;
    if (exp_exc == 0) begin
      exp_sel    = NDEV'(1) << exp_slot;
      exp_we     = store;
      exp_byteen = store ? 4'(((1 << size) - 1) << off) : 4'hF;
      if (store)
        exp_wdata = 32'((longint'(wdata) % (longint'(1) << (8 * size))) << (8 * off));
      else begin
        v = (longint'(slave_data[exp_slot]) >> (8 * off)) % (longint'(1) << (8 * size));
        if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
        exp_rdata = 32'(v);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.dev_req !== 4'b0) begin failures++; $display("[TB] FAIL reset_dev_req: got %b expected 0000", bus.dev_req); end
    checks++; if ({bus.dev_we, bus.dev_byteen} !== 5'b0) begin failures++; $display("[TB] FAIL reset_we_byteen: got %b expected 00000", {bus.dev_we, bus.dev_byteen}); end
    checks++; if ({cpu_ack, cpu_stall} !== 2'b00) begin failures++; $display("[TB] FAIL reset_ack_stall: got %b expected 00", {cpu_ack, cpu_stall}); end
    checks++; if ({cpu_rdata, cpu_exc_out} !== 37'b0) begin failures++; $display("[TB] FAIL reset_rdata_exc: got %h/%h expected 0/0", cpu_rdata, cpu_exc_out); end
    reset = 1'b0;
  endtask

  task automatic test_basic_load();
    ack_noise = '0;
    slave_data = '{32'hDEADBEEF, 32'h1, 32'h2, 32'h3};
    load_slaves();
    apply_stimulus(OP_LW, 32'h100, 32'h0, 5'd0, 0, 1'b0);
    checks++; if (obs_accept_stall !== 1'b1) begin failures++; $display("[TB] FAIL lw_accept_stall: got %b expected 1", obs_accept_stall); end
    checks++; if (obs_ack_cycle !== 3) begin failures++; $display("[TB] FAIL lw_latency: got %0d expected 3", obs_ack_cycle); end
    checks++; if (obs_rdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL lw_rdata: got %h expected deadbeef", obs_rdata); end
    checks++; if (obs_exc !== 5'd0) begin failures++; $display("[TB] FAIL lw_exc: got %0d expected 0", obs_exc); end
    checks++; if ({obs_sel, obs_we, obs_byteen} !== {4'b0001, 1'b0, 4'b1111}) begin failures++; $display("[TB] FAIL lw_bus: got %b/%b/%b expected 0001/0/1111", obs_sel, obs_we, obs_byteen); end
  endtask

  task automatic test_lanes();
    ack_noise = '0;
    apply_stimulus(OP_SB, 32'h7F53, 32'h000000A5, 5'd0, 0, 1'b0);
    checks++; if (obs_byteen !== 4'b1000) begin failures++; $display("[TB] FAIL sb_byteen: got %b expected 1000", obs_byteen); end
    checks++; if (obs_wdata !== 32'hA5000000) begin failures++; $display("[TB] FAIL sb_wdata: got %h expected a5000000", obs_wdata); end
    checks++; if ({obs_sel, obs_we} !== 5'b0010_1) begin failures++; $display("[TB] FAIL sb_sel_we: got %b/%b expected 0010/1", obs_sel, obs_we); end
    checks++; if (obs_rdata !== 32'h0) begin failures++; $display("[TB] FAIL sb_rdata: got %h expected 0", obs_rdata); end
    slave_data[1] = 32'h80123456;
    load_slaves();
    apply_stimulus(OP_LB, 32'h7F53, 32'h0, 5'd0, 0, 1'b0);
    checks++; if (obs_rdata !== 32'hFFFFFF80) begin failures++; $display("[TB] FAIL lb_sext: got %h expected ffffff80", obs_rdata); end
    apply_stimulus(OP_LBU, 32'h7F53, 32'h0, 5'd0, 0, 1'b0);
    checks++; if (obs_rdata !== 32'h00000080) begin failures++; $display("[TB] FAIL lbu_zext: got %h expected 00000080", obs_rdata); end
    apply_stimulus(OP_LH, 32'h7F52, 32'h0, 5'd0, 0, 1'b0);
    checks++; if (obs_rdata !== 32'hFFFF8012) begin failures++; $display("[TB] FAIL lh_sext: got %h expected ffff8012", obs_rdata); end
    apply_stimulus(OP_LHU, 32'h7F50, 32'h0, 5'd0, 0, 1'b0);
    checks++; if (obs_rdata !== 32'h00003456) begin failures++; $display("[TB] FAIL lhu_zext: got %h expected 00003456", obs_rdata); end
    apply_stimulus(OP_SH, 32'h7F52, 32'hFFFF1234, 5'd0, 0, 1'b0);
    checks++; if ({obs_byteen, obs_wdata} !== {4'b1100, 32'h12340000}) begin failures++; $display("[TB] FAIL sh_lanes: got %b/%h expected 1100/12340000", obs_byteen, obs_wdata); end
  endtask

  task automatic test_wait_states();
    ack_noise = 4'b1111;
    apply_stimulus(OP_LW, 32'h200, 32'h0, 5'd0, 4, 1'b0);
    checks++; if (obs_req_cycles !== 5) begin failures++; $display("[TB] FAIL wait_req_cycles: got %0d expected 5", obs_req_cycles); end
    checks++; if (obs_stall_bad !== 1'b0) begin failures++; $display("[TB] FAIL wait_stall: got %b expected 0", obs_stall_bad); end
    checks++; if (obs_ack_count !== 1) begin failures++; $display("[TB] FAIL wait_ack_pulses: got %0d expected 1", obs_ack_count); end
    checks++; if (obs_ack_cycle !== 7) begin failures++; $display("[TB] FAIL wait_latency: got %0d expected 7", obs_ack_cycle); end
    ack_noise = '0;
  endtask

  logic [3:0]      t_op      [7] = '{OP_LH, OP_SW, OP_SH, OP_LW, OP_SW, OP_LW, OP_LW};
  logic [31:0]     t_addr    [7] = '{32'h1, 32'h9000, 32'h8004, 32'h100, 32'hA010, 32'hA010, 32'h7900};
  logic [4:0]      t_exc_in  [7] = '{5'd0, 5'd0, 5'd0, 5'd10, 5'd0, 5'd0, 5'd0};
  logic [4:0]      t_exp_exc [7] = '{5'd4, 5'd5, 5'd5, 5'd10, 5'd5, 5'd0, 5'd0};
  logic [NDEV-1:0] t_exp_sel [7] = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b1000, 4'b0010};

  task automatic test_exceptions();
    ack_noise = '0;
    for (int k = 0; k < 7; k++) begin
      apply_stimulus(t_op[k], t_addr[k], 32'h12345678, t_exc_in[k], 0, 1'b0);
      checks++; if (obs_exc !== t_exp_exc[k]) begin failures++; $display("[TB] FAIL exc_code[%0d]: got %0d expected %0d", k, obs_exc, t_exp_exc[k]); end
      checks++; if (obs_sel !== t_exp_sel[k]) begin failures++; $display("[TB] FAIL exc_sel[%0d]: got %b expected %b", k, obs_sel, t_exp_sel[k]); end
      checks++; if (obs_ack_cycle !== ((t_exp_exc[k] != 0) ? 2 : 3)) begin failures++; $display("[TB] FAIL exc_latency[%0d]: got %0d", k, obs_ack_cycle); end
    end
  endtask

  task automatic test_flush();
    logic bad;
    bad = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_op = OP_SW; cpu_addr = 32'h10; cpu_flush = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (cpu_stall || cpu_ack || (|bus.dev_req)) bad = 1'b1;
    end
    cpu_req = 1'b0; cpu_flush = 1'b0;
    checks++; if (bad !== 1'b0) begin failures++; $display("[TB] FAIL flush_blocks_accept: got %b expected 0", bad); end
    apply_stimulus(OP_SW, 32'h10, 32'hCAFE0001, 5'd0, 2, 1'b1);
    checks++; if ({obs_ack_count, obs_exc, obs_req_cycles} !== {32'd1, 5'd0, 32'd3}) begin failures++; $display("[TB] FAIL flush_mid_access: got ack=%0d exc=%0d req=%0d expected 1/0/3", obs_ack_count, obs_exc, obs_req_cycles); end
  endtask

  task automatic test_reset_busy();
    logic bad;
    @(negedge clk);
    wait_n = 20;
    cpu_req = 1'b1; cpu_op = OP_LW; cpu_addr = 32'h200;
    @(negedge clk);
    cpu_req = 1'b0; cpu_op = 4'd0;
    @(negedge clk); #1;
    checks++; if (bus.dev_req !== 4'b0001) begin failures++; $display("[TB] FAIL rst_busy_req: got %b expected 0001", bus.dev_req); end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if ({bus.dev_req, cpu_stall} !== 5'b0) begin failures++; $display("[TB] FAIL rst_busy_drop: got %b/%b expected 0000/0", bus.dev_req, cpu_stall); end
    reset = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (cpu_ack || (|bus.dev_req)) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy_no_ack: got %b expected 0", bad); end
    wait_n = 0;
  endtask

  task automatic test_back_to_back();
    int acks[$];
    logic bad;
    bad = 1'b0;
    wait_n = 0; ack_noise = '0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_op = OP_LW; cpu_addr = 32'h40;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (cpu_ack) begin acks.push_back(c); if (cpu_stall) bad = 1'b1; end
    end
    cpu_req = 1'b0; cpu_op = 4'd0;
    checks++; if (acks.size() !== 4) begin failures++; $display("[TB] FAIL b2b_ack_count: got %0d expected 4", acks.size()); end
    else begin
      checks++; if (acks[3] - acks[0] !== 12) begin failures++; $display("[TB] FAIL b2b_spacing: got %0d expected 12", acks[3] - acks[0]); end
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("[TB] FAIL b2b_stall_in_done: got %b expected 0", bad); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] addr, wdata;
    logic [4:0]  exc;
    int          waits;
    logic        fl;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(1, 8));
      case ($urandom_range(0, 6))
        0: addr = $urandom_range(32'h0000, 32'h2FFF);
        1: addr = $urandom_range(32'h7000, 32'h77FF);
        2: addr = $urandom_range(32'h7800, 32'h7FFF);
        3: addr = $urandom_range(32'h8000, 32'h8FFF);
        4: addr = $urandom_range(32'hA000, 32'hAFFF);
        5: addr = $urandom_range(32'h9000, 32'h9FFF);
        default: addr = $urandom_range(32'hC000, 32'hFFFF);
      endcase
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      exc = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      wdata = $urandom;
      waits = $urandom_range(0, 3);
      fl = 1'($urandom_range(0, 1));
      ack_noise = 4'($urandom);
      for (int i = 0; i < NDEV; i++) slave_data[i] = $urandom;
      load_slaves();
      ref_model(int'(op), addr, wdata, exc);
      apply_stimulus(op, addr, wdata, exc, waits, fl);
      checks++; if (obs_exc !== exp_exc) begin failures++; $display("[TB] FAIL rnd_exc[%0d]: got %0d expected %0d", n, obs_exc, exp_exc); end
      checks++; if (obs_rdata !== exp_rdata) begin failures++; $display("[TB] FAIL rnd_rdata[%0d]: got %h expected %h", n, obs_rdata, exp_rdata); end
      checks++; if (obs_sel !== exp_sel) begin failures++; $display("[TB] FAIL rnd_sel[%0d]: got %b expected %b", n, obs_sel, exp_sel); end
      checks++; if (obs_ack_cycle !== ((exp_exc != 0) ? 2 : 3 + waits)) begin failures++; $display("[TB] FAIL rnd_latency[%0d]: got %0d", n, obs_ack_cycle); end
      checks++; if ({obs_ack_count, obs_stall_bad} !== {32'd1, 1'b0}) begin failures++; $display("[TB] FAIL rnd_handshake[%0d]: got acks=%0d stall_bad=%b expected 1/0", n, obs_ack_count, obs_stall_bad); end
      if (exp_exc == 0) begin
        checks++; if ({obs_we, obs_byteen, obs_wdata, obs_addr} !== {exp_we, exp_byteen, exp_wdata, addr}) begin
          failures++; $display("[TB] FAIL rnd_bus[%0d]: got %b/%b/%h/%h expected %b/%b/%h/%h", n, obs_we, obs_byteen, obs_wdata, obs_addr, exp_we, exp_byteen, exp_wdata, addr);
        end
      end
    end
    ack_noise = '0;
  endtask

  initial begin
    for (int i = 0; i < NDEV; i++) slave_data[i] = '0;
    load_slaves();
    test_reset();
    test_basic_load();
    test_lanes();
    test_wait_states();
    test_exceptions();
    test_flush();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
